// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       winc,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       wfull,
    output logic                       walmost_full,
    input  logic                       rinc,
    output logic [WIDTH-1:0]           rdata,
    output logic                       rempty,
    output logic                       ralmost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_acc;
    logic             rd_acc;
    logic [CW-1:0]    count_nxt;

    // Acceptance uses the registered flags, so a full FIFO still takes a read and an
    // empty one still takes a write when both are requested together.
    always_comb begin
        wr_acc    = winc && !wfull;
        rd_acc    = rinc && !rempty;
        count_nxt = count;
        if (wr_acc && !rd_acc)
            count_nxt = count + 1'b1;
        else if (rd_acc && !wr_acc)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            wfull         <= 1'b0;
            walmost_full  <= 1'b0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (rd_acc)
                rptr <= rptr + 1'b1;
            count         <= count_nxt;
            wfull         <= (count_nxt == DEPTH_C);
            walmost_full  <= (count_nxt >= AFULL_C);
            rempty        <= (count_nxt == '0);
            ralmost_empty <= (count_nxt <= AEMPTY_C);
            overflow      <= winc && wfull;
            underflow     <= rinc && rempty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wptr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[rptr];
        end else begin : g_std
            logic [WIDTH-1:0] rdata_p1;
            // Read stage: head word captured on the accepting edge.
            always_ff @(posedge clk) begin
                if (rst)
                    rdata_p1 <= '0;
                else if (rd_acc)
                    rdata_p1 <= mem[rptr];
            end
            assign rdata = rdata_p1;
        end
    endgenerate

endmodule
